// File: rtl/prod_pkg.sv
// Shared constants, register-action enum and action decode for the shift-add product register.
// Optional multiplier-load action is present when PROD_MPLIER_LOAD_EN is defined.
package prod_pkg;

  localparam int W_DEF  = 4;
  localparam int PW_DEF = 2 * W_DEF + 1;

`ifdef PROD_MPLIER_LOAD_EN
  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    MLOAD = 2'd3
  } prod_act_e;
`else
  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } prod_act_e;
`endif

  // Priority: multiplier load, then adder load, then shift, else hold.
  function automatic prod_act_e act_decode(input logic ldm, input logic ldp, input logic shp);
    prod_act_e act;
    act = HOLD;
`ifdef PROD_MPLIER_LOAD_EN
    if (ldm) begin
      act = MLOAD;
    end else
`endif
    if (ldp) begin
      act = LOAD;
    end else if (shp) begin
      act = SHIFT;
    end
    if (ldm && !ldp && !shp) begin
      act = act;
    end
    return act;
  endfunction

endpackage

// File: rtl/prod_reg.sv
// Partial-product register of a sequential shift-add multiplier: loads {cin, sum} into the upper
// W+1 bits or shifts the 2W+1-bit value right. PROD_MPLIER_LOAD_EN adds ldm/mplier ports.
module prod_reg
  import prod_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic [W-1:0] sum,
  input  logic         cin,
  input  logic         shp,
  input  logic         ldp,
`ifdef PROD_MPLIER_LOAD_EN
  input  logic         ldm,
  input  logic [W-1:0] mplier,
`endif
  output logic [2*W:0] p
);

  logic      ldm_en;
  prod_act_e act;

`ifdef PROD_MPLIER_LOAD_EN
  assign ldm_en = ldm;
`else
  assign ldm_en = 1'b0;
`endif

  assign act = act_decode(ldm_en, ldp, shp);

  // Load leaves the low half untouched so the remaining multiplier bits survive.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      p <= '0;
    end else begin
      case (act)
        LOAD:    p[2*W:W] <= {cin, sum};
        SHIFT:   p <= {1'b0, p[2*W:1]};
`ifdef PROD_MPLIER_LOAD_EN
        MLOAD:   p <= {{(W+1){1'b0}}, mplier};
`endif
        default: p <= p;
      endcase
    end
  end

endmodule

// File: tb/tb_prod_reg.sv
// Directed bench for prod_reg: table of load/shift/hold vectors plus reset sequences and,
// with PROD_MPLIER_LOAD_EN, a full 13 x 11 multiply.
module tb_prod_reg;
  import prod_pkg::*;

  localparam int W  = 4;
  localparam int PW = 2 * W + 1;

  logic          clk;
  logic          clr_n;
  logic [W-1:0]  sum;
  logic          cin;
  logic          shp;
  logic          ldp;
  logic [PW-1:0] p;
`ifdef PROD_MPLIER_LOAD_EN
  logic          ldm;
  logic [W-1:0]  mplier;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;

  prod_reg #(.W(W)) dut (
    .clk    (clk),
    .clr_n  (clr_n),
    .sum    (sum),
    .cin    (cin),
    .shp    (shp),
    .ldp    (ldp),
`ifdef PROD_MPLIER_LOAD_EN
    .ldm    (ldm),
    .mplier (mplier),
`endif
    .p      (p)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic          ldp;
    logic          shp;
    logic          cin;
    logic [W-1:0]  sum;
    logic [PW-1:0] exp_p;
  } vec_t;

  vec_t vecs[18];

  // scoreboard
  task automatic check(input string name, input logic [PW-1:0] exp_v);
    vec_cnt++;
    if (p !== exp_v) begin
      err_cnt++;
      $display("FAIL %s: p=0x%03h expected 0x%03h", name, p, exp_v);
    end
  endtask

  // driver tasks
  task automatic drive(input logic l, input logic s, input logic c, input logic [W-1:0] sm);
    ldp = l;
    shp = s;
    cin = c;
    sum = sm;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{"load_1f0",   1'b1, 1'b0, 1'b1, 4'hF, 9'h1F0};
    vecs[1]  = '{"shift_0f8",  1'b0, 1'b1, 1'b0, 4'h0, 9'h0F8};
    vecs[2]  = '{"shift_07c",  1'b0, 1'b1, 1'b1, 4'h3, 9'h07C};
    vecs[3]  = '{"load_keep",  1'b1, 1'b0, 1'b0, 4'hF, 9'h0FC};
    vecs[4]  = '{"priority",   1'b1, 1'b1, 1'b1, 4'hA, 9'h1AC};
    vecs[5]  = '{"hold",       1'b0, 1'b0, 1'b0, 4'h5, 9'h1AC};
    vecs[6]  = '{"drain_1",    1'b0, 1'b1, 1'b0, 4'h0, 9'h0D6};
    vecs[7]  = '{"drain_2",    1'b0, 1'b1, 1'b0, 4'h0, 9'h06B};
    vecs[8]  = '{"drain_3",    1'b0, 1'b1, 1'b0, 4'h0, 9'h035};
    vecs[9]  = '{"drain_4",    1'b0, 1'b1, 1'b0, 4'h0, 9'h01A};
    vecs[10] = '{"drain_5",    1'b0, 1'b1, 1'b0, 4'h0, 9'h00D};
    vecs[11] = '{"drain_6",    1'b0, 1'b1, 1'b0, 4'h0, 9'h006};
    vecs[12] = '{"drain_7",    1'b0, 1'b1, 1'b0, 4'h0, 9'h003};
    vecs[13] = '{"drain_8",    1'b0, 1'b1, 1'b0, 4'h0, 9'h001};
    vecs[14] = '{"drain_9",    1'b0, 1'b1, 1'b0, 4'h0, 9'h000};
    vecs[15] = '{"drain_stay", 1'b0, 1'b1, 1'b1, 4'hF, 9'h000};
    vecs[16] = '{"load_150",   1'b1, 1'b0, 1'b1, 4'h5, 9'h150};
    vecs[17] = '{"shift_0a8",  1'b0, 1'b1, 1'b0, 4'h0, 9'h0A8};

    clr_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 4'h0);
`ifdef PROD_MPLIER_LOAD_EN
    ldm    = 1'b0;
    mplier = 4'h0;
`endif

    // reset held across edges, then released with no enables
    #3;
    check("reset_async", 9'h000);
    drive(1'b1, 1'b0, 1'b1, 4'hF);
    tick();
    check("reset_hold", 9'h000);
    drive(1'b0, 1'b0, 1'b0, 4'h0);
    clr_n = 1'b1;
    tick();
    check("reset_release", 9'h000);

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].ldp, vecs[i].shp, vecs[i].cin, vecs[i].sum);
      tick();
      check(vecs[i].name, vecs[i].exp_p);
    end

    // asynchronous clear between edges with a load pending
    drive(1'b1, 1'b0, 1'b1, 4'h7);
    #2;
    clr_n = 1'b0;
    #1;
    check("clr_async_mid", 9'h000);
    tick();
    check("clr_abort_load", 9'h000);
    drive(1'b0, 1'b0, 1'b0, 4'h0);
    clr_n = 1'b1;
    tick();
    check("clr_release", 9'h000);

`ifdef PROD_MPLIER_LOAD_EN
    begin
      logic [PW-1:0] exp_v;
      logic [W:0]    s;
      ldm    = 1'b1;
      mplier = 4'd13;
      drive(1'b1, 1'b1, 1'b1, 4'hF);
      tick();
      ldm = 1'b0;
      exp_v = 9'h00D;
      check("mload_13", exp_v);
      for (int it = 0; it < W; it++) begin
        if (exp_v[0]) begin
          s = {1'b0, exp_v[7:4]} + 5'd11;
          drive(1'b1, 1'b0, s[4], s[3:0]);
          tick();
          exp_v = {s, exp_v[3:0]};
          check("mul_add", exp_v);
        end
        drive(1'b0, 1'b1, 1'b0, 4'h0);
        tick();
        exp_v = exp_v >> 1;
        check("mul_shift", exp_v);
      end
      drive(1'b0, 1'b0, 1'b0, 4'h0);
      tick();
      check("mul_final_143", 9'd143);

      // restart and abort mid-sequence
      ldm    = 1'b1;
      mplier = 4'd9;
      tick();
      ldm = 1'b0;
      check("mload_9", 9'h009);
      drive(1'b1, 1'b0, 1'b0, 4'hB);
      tick();
      check("mul2_add", 9'h0B9);
      drive(1'b0, 1'b1, 1'b0, 4'h0);
      #2;
      clr_n = 1'b0;
      #1;
      check("mul2_abort", 9'h000);
      tick();
      clr_n = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 4'h0);
      tick();
      check("mul2_after_clr", 9'h000);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
